hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash and memory-wait freeze.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_timeout,
  output logic [1:0]  hz_state,
  output logic [15:0] stall_cycles
);
  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] MEM_WAIT = 2'b01;
  localparam logic [1:0] BR_FLUSH = 2'b10;

  logic [1:0] state_reg, state_next;
  logic [7:0] wait_cnt_reg;
  logic       mem_timeout_reg;
  logic       load_use;
  logic       waiting;

  assign load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign waiting  = (state_reg == MEM_WAIT) && mem_busy;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_next   = RUN;
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush}           = 3'b111;
    end else begin
      case (state_reg)
        MEM_WAIT: begin
          // Release cycle behaves as plain RUN; a held branch acts next cycle.
          if (mem_busy) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
            state_next = MEM_WAIT;
          end
        end
        BR_FLUSH: begin
          // Squash the fetch that was already in flight when the branch resolved.
          if_id_flush = 1'b1;
        end
        default: begin
          if (branch_taken) begin
            {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
            state_next = BR_FLUSH;
          end else if (mem_busy) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
            state_next = MEM_WAIT;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (waiting) begin
        if (wait_cnt_reg != 8'hFF) wait_cnt_reg <= wait_cnt_reg + 8'd1;
        if (wait_cnt_reg >= 8'd254) mem_timeout_reg <= 1'b1;
      end else begin
        wait_cnt_reg <= 8'd0;
      end
    end
  end

  assign mem_timeout = mem_timeout_reg;
  assign hz_state    = state_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg <= 16'd0;
    end else if (!pc_write && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end
  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic vs a reference model.
module tb_hazard_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  if_id_rs = 5'd0, if_id_rt = 5'd0, id_ex_rt = 5'd0;
  logic        id_ex_memread = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
  logic [1:0]  hz_state;
  logic [15:0] stall_cycles;
  logic [6:0]  dut_vec;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0=running, 1=waiting on memory, 2=flushing after branch.
  int m_mode = 0;
  int m_wait = 0;
  bit m_to = 1'b0;
  int m_stall = 0;

  hazard_ctrl dut (
    .clock(clock), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_timeout(mem_timeout),
    .hz_state(hz_state), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  assign dut_vec = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                    if_id_flush, id_ex_flush, ex_mem_flush};

  function automatic logic [6:0] model_vec();
    bit lu;
    lu = id_ex_memread && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
    if (reset) return 7'b0000_111;
    if (m_mode == 2) return 7'b1111_100;
    if (m_mode == 1) return mem_busy ? 7'b0000_000 : 7'b1111_000;
    if (branch_taken) return 7'b1111_111;
    if (mem_busy) return 7'b0000_000;
    if (lu) return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_stall();
`ifdef HAZARD_PERF_CNT_EN
    return 16'(m_stall);
`else
    return 16'd0;
`endif
  endfunction

  // Compare everything against the model, then clock once and advance the model.
  task automatic step(input string tag);
    logic [6:0] ev;
    #2;
    ev = model_vec();
    chk({tag, ".vec"}, 32'(dut_vec), 32'(ev));
    chk({tag, ".state"}, 32'(hz_state), 32'(m_mode));
    chk({tag, ".timeout"}, 32'(mem_timeout), 32'(m_to));
    chk({tag, ".stall"}, 32'(stall_cycles), 32'(exp_stall()));
    $display("step %s rst=%0b br=%0b busy=%0b vec=%b state=%0d to=%0b stall=%0d",
             tag, reset, branch_taken, mem_busy, dut_vec, hz_state, mem_timeout, stall_cycles);
    @(posedge clock);
    if (reset) begin
      m_mode = 0; m_wait = 0; m_to = 1'b0; m_stall = 0;
    end else begin
      if (ev[6] == 1'b0 && m_stall < 65535) m_stall++;
      if (m_mode == 1 && mem_busy) begin
        if (m_wait < 255) m_wait++;
        if (m_wait == 255) m_to = 1'b1;
      end else begin
        m_wait = 0;
      end
      case (m_mode)
        0: m_mode = branch_taken ? 2 : (mem_busy ? 1 : 0);
        1: m_mode = mem_busy ? 1 : 0;
        default: m_mode = 0;
      endcase
    end
    #1;
  endtask

  task automatic step_exp(input string tag, input logic [6:0] exp);
    #2;
    chk({tag, ".const"}, 32'(dut_vec), 32'(exp));
    #(-0);
    step(tag);
  endtask

  int s0;

  initial begin
    @(posedge clock); #1;
    // Reset behaviour.
    reset = 1'b1;
    step_exp("rst0", 7'b0000_111);
    step_exp("rst1", 7'b0000_111);
    reset = 1'b0;
    #1;
    chk("rst.state", 32'(hz_state), 32'd0);
    chk("rst.timeout", 32'(mem_timeout), 32'd0);
    chk("rst.stall", 32'(stall_cycles), 32'd0);
    step_exp("idle", 7'b1111_000);

    // Load-use bubble lasts exactly one cycle.
    id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
    step_exp("lu", 7'b0011_010);
    id_ex_memread = 1'b0;
    step_exp("lu.done", 7'b1111_000);

    // Register zero never causes a hazard.
    id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    step_exp("lu.r0", 7'b1111_000);

    // Branch wins over load-use; branch ignored while flushing.
    id_ex_rt = 5'd5; if_id_rs = 5'd5; branch_taken = 1'b1;
    step_exp("br", 7'b1111_111);
    chk("br.state", 32'(hz_state), 32'd2);
    id_ex_memread = 1'b0;
    step_exp("br.flush", 7'b1111_100);
    branch_taken = 1'b0;
    chk("br.back", 32'(hz_state), 32'd0);
    step_exp("br.run", 7'b1111_000);

    // Three-cycle memory wait.
    s0 = stall_cycles;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step_exp("mw3", 7'b0000_000);
    mem_busy = 1'b0;
    step_exp("mw3.rel", 7'b1111_000);
`ifdef HAZARD_PERF_CNT_EN
    chk("mw3.stall", 32'(stall_cycles) - 32'(s0), 32'd3);
`else
    chk("mw3.stall", 32'(stall_cycles), 32'd0);
`endif

    // Watchdog: long wait sets a sticky timeout.
    mem_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 250) chk("wd.early", 32'(mem_timeout), 32'd0);
      step("wd");
    end
    chk("wd.set", 32'(mem_timeout), 32'd1);
    mem_busy = 1'b0;
    for (int i = 0; i < 5; i++) step("wd.hold");
    chk("wd.sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a memory wait.
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) step("mw.pre");
    reset = 1'b1;
    step_exp("mw.rst", 7'b0000_111);
    reset = 1'b0; mem_busy = 1'b0;
    #1;
    chk("mw.rst.state", 32'(hz_state), 32'd0);
    chk("mw.rst.timeout", 32'(mem_timeout), 32'd0);
    chk("mw.rst.stall", 32'(stall_cycles), 32'd0);
    step_exp("mw.rst.run", 7'b1111_000);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      if_id_rs      = 5'($urandom_range(0, 3));
      if_id_rt      = 5'($urandom_range(0, 3));
      id_ex_rt      = 5'($urandom_range(0, 3));
      id_ex_memread = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 5) == 0);
      mem_busy      = (m_mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
